tt_host_driver: RTL and testbench
=================================

# tt_host_driver

Host-side initiator for the tile's mode-multiplexed pin interface. It accepts one operation per request: a 2-bit mode, two 6-bit operands and a carry-in. It packs them onto the tile's `ui_in`/`uio_in` pins, waits a programmable settle time, captures `uo_out` and returns it over a valid/ready response channel. It sits in the verification/FPGA-bring-up harness, directly wired to the tile's dedicated pins.

## Interface
Parameters:
- `SETTLE`, 2: clock edges between pins being driven and `uo_out` being captured; legal range 1..15.
- `CW`, 4: width of the settle counter; must satisfy 2^CW > SETTLE.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: driver can accept a request.
- `req_mode` in 2: tile mode. 0 = adder, 1 = half-latch bank, 2/3 = unused tile modes.
- `req_a` in 6: operand A, or latch p inputs in `[3:0]`.
- `req_b` in 6: operand B, or latch n inputs in `[3:0]`.
- `req_cin` in 1: adder carry-in; ignored in other modes.
- `rsp_valid` out 1: captured result present.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_data` out 8: captured `uo_out`.
- `rsp_mode` out 2: mode of the transaction that produced `rsp_data`.
- `pin_ui` out 8: to tile `ui_in`. Bits `[7:6]` = mode, `[5:0]` = A.
- `pin_uio` out 8: to tile `uio_in`. Bit 7 = cin, bit 6 = 0, `[5:0]` = B.
- `pin_uo` in 8: from tile `uo_out`.

## Operation
- FSM states: IDLE, SWITCH, SETTLE, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch the request into internal registers.
  - If `req_mode` differs from the currently driven mode: drive the new mode on `pin_ui[7:6]` with all data bits 0, then go to SWITCH.
  - Otherwise: drive the full pin image, load the counter with SETTLE-1, then go to SETTLE.
- SWITCH: lasts exactly 1 cycle, so latch or adder inputs never see old data under the new mode. Then drive the full pin image, load the counter, go to SETTLE.
- SETTLE: decrement the counter each edge. On the edge where the counter is 0, capture `pin_uo` into `rsp_data`, set `rsp_mode`, assert `rsp_valid`, go to RESP.
- RESP: hold `rsp_valid`, `rsp_data` and `rsp_mode` stable until `rsp_ready`=1, then go to IDLE.
- Pins are registered outputs. They hold the last driven image in IDLE and RESP and change only on request acceptance or on leaving SWITCH.
- Pin packing:
  - Mode 0: `pin_ui`={mode,A}, `pin_uio`={cin,1'b0,B}.
  - Mode 1: same packing, with cin forced to 0.
  - Modes 2/3: same packing, cin forced to 0. The tile is expected to return 0.
- Reset (asynchronous, any state including mid-SETTLE): state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_mode`=0, `pin_ui`=0, `pin_uio`=0, counter=0, driven-mode register=0. No response is produced for an interrupted transaction.

## Timing
- Acceptance edge E0 = first edge with `req_valid`&&`req_ready`. Pins show the new image after E0 (same mode) or after E0+1 (mode switch).
- `rsp_valid` rises after edge E0+SETTLE (same mode) or E0+SETTLE+1 (mode switch). `uo_out` is sampled on that same edge.
- `req_ready` is 0 from E0+1 until the cycle after the `rsp_valid`&&`rsp_ready` edge. There is no request/response bypass.
- Back-to-back throughput: one transaction per SETTLE+2 cycles when the consumer holds `rsp_ready`=1.
- `rsp_ready` already high when `rsp_valid` rises: the response completes on the next edge.
- `req_valid` asserted outside IDLE: ignored. The requester must hold it until `req_ready`.

## Structure
- Package `tt_host_pkg` holds:
  - the state enum (IDLE/SWITCH/SETTLE/RESP);
  - mode constants `MODE_ADD`=2'd0, `MODE_LATCH`=2'd1;
  - a pin-packing function (mode, A, B, cin) -> {ui, uio}.
- Sub-module `settle_timer`: loadable down-counter of width CW with a `zero` flag. All other logic lives in `tt_host_driver`.

## Test plan
- Reset mid-SETTLE: assert `rst_n`=0 at cycle E0+1. Required: all outputs 0, `req_ready`=1, and no `rsp_valid` afterwards.
- Adder, SETTLE=2, mode 0 already driven: A=6'd45, B=6'd27, cin=1, tile model returns 8'd73. Required: `pin_ui`=8'h2D, `pin_uio`=8'h9B; `rsp_valid` after E0+2 with `rsp_data`=8'h49, `rsp_mode`=0.
- Mode switch 0→1, A=6'h0F, B=6'h00: one cycle of `pin_ui`=8'h40, `pin_uio`=8'h00, then `pin_ui`=8'h4F. `rsp_valid` arrives one cycle later than in the previous scenario.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles. Required: `rsp_valid` and `rsp_data` stay stable and `req_ready`=0 throughout. `req_ready`=1 the cycle after `rsp_ready` rises.
- Back-to-back: three mode-0 requests with `rsp_ready` tied to 1. Required: acceptances exactly SETTLE+2=4 cycles apart and responses in request order.
- Mode 3 with A=B=6'h3F and a tile returning 0. Required: `pin_uio`=8'h3F with cin bit 0, and `rsp_data`=8'h00, `rsp_mode`=3.

Source files
------------

// File: rtl/tt_host_pkg.sv
// Shared types and helpers for the tile host driver: FSM states, tile mode
// codes and the request-to-pin packing rule.
package tt_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [1:0] MODE_ADD   = 2'd0;
  localparam logic [1:0] MODE_LATCH = 2'd1;

  typedef struct packed {
    logic [7:0] ui;
    logic [7:0] uio;
  } pins_t;

  // Carry-in only reaches the tile in adder mode; every other mode sees 0.
  function automatic pins_t pack_pins(input logic [1:0] mode,
                                      input logic [5:0] a,
                                      input logic [5:0] b,
                                      input logic       cin);
    pins_t p;
    p.ui  = {mode, a};
    p.uio = {(mode == MODE_ADD) ? cin : 1'b0, 1'b0, b};
    return p;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that measures the tile settle window; zero flags
// the edge on which the tile output may be sampled.
module settle_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the count parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tt_host_driver.sv
// Host-side initiator for the tile pin interface: accepts one request,
// drives the tile pins, waits the settle window, returns uo_out.
//
// state  | meaning
// IDLE   | ready for a request; pins hold the last image
// SWITCH | new mode on pins with data bits 0, one cycle only
// SETTLE | full image on pins, counting down the settle window
// RESP   | captured result held until the consumer takes it
module tt_host_driver
  import tt_host_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int CW     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_mode,
  input  logic [5:0] req_a,
  input  logic [5:0] req_b,
  input  logic       req_cin,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_mode,
  output logic [7:0] pin_ui,
  output logic [7:0] pin_uio,
  input  logic [7:0] pin_uo
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [1:0] drv_mode_q, drv_mode_d;
  logic [1:0] mode_q, mode_d;
  logic [5:0] a_q, a_d;
  logic [5:0] b_q, b_d;
  logic       cin_q, cin_d;
  logic [7:0] pin_ui_q, pin_ui_d;
  logic [7:0] pin_uio_q, pin_uio_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [1:0] rsp_mode_q, rsp_mode_d;
  logic       tmr_load, tmr_dec, tmr_zero;
  pins_t      pins_req, pins_held;

  settle_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (LOAD_VAL),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Next-state, pin image and response capture.
  always_comb begin
    state_d    = state_q;
    drv_mode_d = drv_mode_q;
    mode_d     = mode_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    pin_ui_d   = pin_ui_q;
    pin_uio_d  = pin_uio_q;
    rsp_data_d = rsp_data_q;
    rsp_mode_d = rsp_mode_q;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    pins_req   = pack_pins(req_mode, req_a, req_b, req_cin);
    pins_held  = pack_pins(mode_q, a_q, b_q, cin_q);

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          mode_d = req_mode;
          a_d    = req_a;
          b_d    = req_b;
          cin_d  = req_cin;
          if (req_mode != drv_mode_q) begin
            // Present the new mode with blank data so the tile never
            // interprets stale operands under the wrong mode.
            pin_ui_d   = {req_mode, 6'b0};
            pin_uio_d  = 8'h00;
            drv_mode_d = req_mode;
            state_d    = ST_SWITCH;
          end else begin
            pin_ui_d  = pins_req.ui;
            pin_uio_d = pins_req.uio;
            tmr_load  = 1'b1;
            state_d   = ST_SETTLE;
          end
        end
      end
      ST_SWITCH: begin
        pin_ui_d  = pins_held.ui;
        pin_uio_d = pins_held.uio;
        tmr_load  = 1'b1;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          rsp_data_d = pin_uo;
          rsp_mode_d = mode_q;
          state_d    = ST_RESP;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request, pin and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      drv_mode_q <= 2'd0;
      mode_q     <= 2'd0;
      a_q        <= 6'd0;
      b_q        <= 6'd0;
      cin_q      <= 1'b0;
      pin_ui_q   <= 8'h00;
      pin_uio_q  <= 8'h00;
      rsp_data_q <= 8'h00;
      rsp_mode_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      drv_mode_q <= drv_mode_d;
      mode_q     <= mode_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      pin_ui_q   <= pin_ui_d;
      pin_uio_q  <= pin_uio_d;
      rsp_data_q <= rsp_data_d;
      rsp_mode_q <= rsp_mode_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_mode  = rsp_mode_q;
  assign pin_ui    = pin_ui_q;
  assign pin_uio   = pin_uio_q;

endmodule

// File: tb/tb_tt_host_driver.sv
// Self-checking bench for tt_host_driver with a behavioural tile model.
module tb_tt_host_driver;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_mode = 2'd0;
  logic [5:0] req_a = 6'd0;
  logic [5:0] req_b = 6'd0;
  logic       req_cin = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic [1:0] rsp_mode;
  logic [7:0] pin_ui;
  logic [7:0] pin_uio;
  logic [7:0] pin_uo;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [1:0] ref_mode = 2'd0;

  tt_host_driver #(.SETTLE(SETTLE), .CW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_mode  (rsp_mode),
    .pin_ui    (pin_ui),
    .pin_uio   (pin_uio),
    .pin_uo    (pin_uo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Tile: adder in mode 0, latch bank echoes p/n nibbles in mode 1, 0 otherwise.
  always_comb begin
    pin_uo = 8'h00;
    case (pin_ui[7:6])
      2'd0: pin_uo = {2'b00, pin_ui[5:0]} + {2'b00, pin_uio[5:0]} + {7'd0, pin_uio[7]};
      2'd1: pin_uo = {pin_ui[3:0], pin_uio[3:0]};
      default: pin_uo = 8'h00;
    endcase
  end

  // Expected results from the request fields, independent of pins.
  function automatic logic [7:0] ref_data(input logic [1:0] m, input logic [5:0] a,
                                         input logic [5:0] b, input logic c);
    if (m == 2'd0) return 8'(a) + 8'(b) + 8'(c);
    if (m == 2'd1) return {a[3:0], b[3:0]};
    return 8'h00;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return just after the acceptance edge.
  task automatic accept(input logic [1:0] m, input logic [5:0] a, input logic [5:0] b,
                        input logic c);
    int n;
    n = 0;
    req_mode = m; req_a = a; req_b = b; req_cin = c; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    check("accept_timeout", 32'(n < 50), 32'd1);
    step();
    req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic txn(input string nm, input logic [1:0] m, input logic [5:0] a,
                     input logic [5:0] b, input logic c, input logic [7:0] eui,
                     input logic [7:0] euio, input logic [7:0] edata, input int elat,
                     input int bp);
    int lat;
    logic sw;
    logic [7:0] held;
    sw = (m != ref_mode);
    rsp_ready = (bp == 0);
    accept(m, a, b, c);
    ref_mode = m;
    lat = 0;
    check({nm, "_ready_low"}, 32'(req_ready), 32'd0);
    if (sw) begin
      check({nm, "_sw_ui"}, 32'(pin_ui), 32'({m, 6'b0}));
      check({nm, "_sw_uio"}, 32'(pin_uio), 32'd0);
      step();
      lat = 1;
    end
    check({nm, "_ui"}, 32'(pin_ui), 32'(eui));
    check({nm, "_uio"}, 32'(pin_uio), 32'(euio));
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'(elat));
    check({nm, "_data"}, 32'(rsp_data), 32'(edata));
    check({nm, "_mode"}, 32'(rsp_mode), 32'(m));
    held = rsp_data;
    for (int i = 0; i < bp; i++) begin
      step();
      check({nm, "_bp_valid"}, 32'(rsp_valid), 32'd1);
      check({nm, "_bp_data"}, 32'(rsp_data), 32'(held));
      check({nm, "_bp_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    check({nm, "_done_valid"}, 32'(rsp_valid), 32'd0);
    check({nm, "_done_ready"}, 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [5:0] a;
    logic [5:0] b;
    logic       cin;
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] data;
    int         lat;
  } vec_t;

  vec_t tbl[4];
  int acc[3];

  initial begin
    int seen;
    logic [1:0] m;
    logic [5:0] a, b;
    logic c;

    tbl[0] = '{2'd0, 6'd45,  6'd27,  1'b1, 8'h2D, 8'h9B, 8'h49, SETTLE};
    tbl[1] = '{2'd1, 6'h0F,  6'h00,  1'b0, 8'h4F, 8'h00, 8'hF0, SETTLE + 1};
    tbl[2] = '{2'd3, 6'h3F,  6'h3F,  1'b1, 8'hFF, 8'h3F, 8'h00, SETTLE + 1};
    tbl[3] = '{2'd0, 6'd1,   6'd2,   1'b1, 8'h01, 8'h82, 8'h04, SETTLE + 1};

    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_mode", 32'(rsp_mode), 32'd0);
    check("rst_ui", 32'(pin_ui), 32'd0);
    check("rst_uio", 32'(pin_uio), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      txn($sformatf("vec%0d", i), tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].cin,
          tbl[i].ui, tbl[i].uio, tbl[i].data, tbl[i].lat, 0);
    end

    txn("backpressure", 2'd0, 6'd10, 6'd20, 1'b0, 8'h0A, 8'h14, 8'd30, SETTLE, 5);

    for (int i = 0; i < 3; i++) begin
      txn($sformatf("b2b%0d", i), 2'd0, 6'(i + 3), 6'(i * 7), 1'b1,
          {2'b00, 6'(i + 3)}, {2'b10, 6'(i * 7)}, 8'(i + 3 + i * 7 + 1), SETTLE, 0);
      acc[i] = acc_cyc;
    end
    check("b2b_gap01", 32'(acc[1] - acc[0]), 32'(SETTLE + 2));
    check("b2b_gap12", 32'(acc[2] - acc[1]), 32'(SETTLE + 2));

    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom_range(3, 0));
      a = 6'($urandom);
      b = 6'($urandom);
      c = 1'($urandom);
      txn($sformatf("rnd%0d", i), m, a, b, c, {m, a},
          {(m == 2'd0) ? c : 1'b0, 1'b0, b}, ref_data(m, a, b, c),
          (m != ref_mode) ? SETTLE + 1 : SETTLE, int'($urandom_range(3, 0)));
    end

    rsp_ready = 1'b1;
    accept(ref_mode, 6'd5, 6'd6, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_data", 32'(rsp_data), 32'd0);
    check("midrst_mode", 32'(rsp_mode), 32'd0);
    check("midrst_ui", 32'(pin_ui), 32'd0);
    check("midrst_uio", 32'(pin_uio), 32'd0);
    step();
    rst_n = 1'b1;
    ref_mode = 2'd0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);

    txn("post_rst", 2'd0, 6'd45, 6'd27, 1'b1, 8'h2D, 8'h9B, 8'h49, SETTLE, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
